// File: rtl/pcie_dest_drain.sv
// pcie_dest_drain: round-robin drain of the D0/D1 destination FIFOs into one dest-tagged stream.
// Optional per-destination accepted-word counters are built when PCIE_DRAIN_CNT_EN is defined.
module pcie_dest_drain #(
  parameter int unsigned BITNUMBER = 6,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 D0_can_pop,
  input  logic                 D1_can_pop,
  input  logic [BITNUMBER-1:0] data_in0,
  input  logic [BITNUMBER-1:0] data_in1,
  input  logic                 ready_in,
  output logic                 pop_D0,
  output logic                 pop_D1,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 dest_out,
  output logic                 valid_out,
  output logic                 drain_idle,
  output logic [CNT_WIDTH-1:0] cnt_D0,
  output logic [CNT_WIDTH-1:0] cnt_D1
);

  typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

  state_e               state_q, state_d;
  logic                 pop0_q, pop0_d, pop1_q, pop1_d;
  logic                 cap_q, cap_d, cap_dest_q, cap_dest_d;
  logic                 rr_q, rr_d;
  logic [BITNUMBER-1:0] buf_data_q [2];
  logic [BITNUMBER-1:0] buf_data_d [2];
  logic [1:0]           buf_dest_q, buf_dest_d;
  logic                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]           occ_q, occ_d;
  logic                 deq, pending, can_issue, gnt1;
  logic [2:0]           held;

  assign valid_out  = (occ_q != 2'd0);
  assign data_out   = valid_out ? buf_data_q[rd_ptr_q] : '0;
  assign dest_out   = valid_out & buf_dest_q[rd_ptr_q];
  assign pop_D0     = pop0_q;
  assign pop_D1     = pop1_q;
  assign deq        = valid_out & ready_in;
  assign pending    = pop0_q | pop1_q | cap_q | valid_out;
  assign drain_idle = (state_q == StIdle) & ~pending;

  // Words owed to the sink once this cycle's dequeue is taken; at most two may be outstanding.
  assign held      = 3'(occ_q) + 3'(pop0_q | pop1_q) + 3'(cap_q) - 3'(deq);
  assign can_issue = (state_q == StActive) & enable & (held < 3'd2);

  always_comb begin
    pop0_d = 1'b0;
    pop1_d = 1'b0;
    rr_d   = rr_q;
    gnt1   = 1'b0;
    if (can_issue && (D0_can_pop || D1_can_pop)) begin
      gnt1   = (D0_can_pop && D1_can_pop) ? rr_q : D1_can_pop;
      pop1_d = gnt1;
      pop0_d = ~gnt1;
      rr_d   = ~gnt1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = StActive;
      StActive: if (!enable) state_d = pending ? StFlush : StIdle;
      StFlush: begin
        if (enable) begin
          state_d = StActive;
        end else if (!pending) begin
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cap_d      = pop0_q | pop1_q;
    cap_dest_d = pop1_q;
    buf_data_d = buf_data_q;
    buf_dest_d = buf_dest_q;
    if (cap_q) begin
      buf_data_d[wr_ptr_q] = cap_dest_q ? data_in1 : data_in0;
      buf_dest_d[wr_ptr_q] = cap_dest_q;
    end
    wr_ptr_d = wr_ptr_q ^ cap_q;
    rd_ptr_d = rd_ptr_q ^ deq;
    occ_d    = occ_q + 2'(cap_q) - 2'(deq);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pop0_q     <= 1'b0;
      pop1_q     <= 1'b0;
      cap_q      <= 1'b0;
      cap_dest_q <= 1'b0;
      rr_q       <= 1'b0;
      buf_data_q <= '{default: '0};
      buf_dest_q <= 2'b00;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      pop0_q     <= pop0_d;
      pop1_q     <= pop1_d;
      cap_q      <= cap_d;
      cap_dest_q <= cap_dest_d;
      rr_q       <= rr_d;
      buf_data_q <= buf_data_d;
      buf_dest_q <= buf_dest_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
    end
  end

`ifdef PCIE_DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (deq) begin
      if (dest_out) begin
        cnt1_d = cnt1_q + CNT_WIDTH'(1);
      end else begin
        cnt0_d = cnt0_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt_D0 = cnt0_q;
  assign cnt_D1 = cnt1_q;
`else
  assign cnt_D0 = '0;
  assign cnt_D1 = '0;
`endif

endmodule

// File: tb/tb_pcie_dest_drain.sv
// Bench for pcie_dest_drain: queue-based FIFO models, a scoreboard of popped words and a
// round-robin/credit reference checked every cycle, plus directed scenario tasks.
module tb_pcie_dest_drain;
  localparam int unsigned BW = 6;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          ready_in = 1'b0;
  logic          D0_can_pop, D1_can_pop;
  logic [BW-1:0] data_in0 = '0;
  logic [BW-1:0] data_in1 = '0;
  logic          pop_D0, pop_D1, dest_out, valid_out, drain_idle;
  logic [BW-1:0] data_out;
  logic [CW-1:0] cnt_D0, cnt_D1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [BW-1:0] q0[$], q1[$];
  int            n0 = 0, n1 = 0;
  logic [BW:0]   exp_q[$];  // {dest, data} popped but not yet accepted
  logic [BW:0]   got_q[$];  // {dest, data} accepted by the sink
  bit            pops_q[$]; // side of each pop, in order
  bit            last_gnt = 1'b1;
  bit            pc0 = 1'b0, pc1 = 1'b0;
  int            m_cnt0 = 0, m_cnt1 = 0;
  bit            s0, s1, side;
  logic [BW:0]   mon_e;
  logic [CW-1:0] e_cnt0, e_cnt1;

  pcie_dest_drain #(.BITNUMBER(BW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .D0_can_pop (D0_can_pop),
    .D1_can_pop (D1_can_pop),
    .data_in0   (data_in0),
    .data_in1   (data_in1),
    .ready_in   (ready_in),
    .pop_D0     (pop_D0),
    .pop_D1     (pop_D1),
    .data_out   (data_out),
    .dest_out   (dest_out),
    .valid_out  (valid_out),
    .drain_idle (drain_idle),
    .cnt_D0     (cnt_D0),
    .cnt_D1     (cnt_D1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Upstream FIFOs: can_pop already accounts for a pop in progress.
  assign D0_can_pop = (n0 > (pop_D0 ? 1 : 0));
  assign D1_can_pop = (n1 > (pop_D1 ? 1 : 0));

  always begin
    @(negedge clk);
    s0 = pop_D0;
    s1 = pop_D1;
    @(posedge clk);
    #1;
    if (reset) begin
      if (s0 && n0 > 0) begin data_in0 = q0.pop_front(); n0--; end
      if (s1 && n1 > 0) begin data_in1 = q1.pop_front(); n1--; end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete(); got_q.delete(); pops_q.delete();
      last_gnt = 1'b1; pc0 = 1'b0; pc1 = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
`ifdef PCIE_DRAIN_CNT_EN
      e_cnt0 = CW'(m_cnt0);
      e_cnt1 = CW'(m_cnt1);
`else
      e_cnt0 = '0;
      e_cnt1 = '0;
`endif
      checks++;
      if (cnt_D0 !== e_cnt0 || cnt_D1 !== e_cnt1) begin
        errors++;
        $display("FAIL counters: got %0d/%0d want %0d/%0d", cnt_D0, cnt_D1, e_cnt0, e_cnt1);
      end
      if (valid_out && ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: got word %h with nothing popped", {dest_out, data_out});
        end else begin
          mon_e = exp_q.pop_front();
          if ({dest_out, data_out} !== mon_e) begin
            errors++;
            $display("FAIL scoreboard: got %h want %h", {dest_out, data_out}, mon_e);
          end
        end
        got_q.push_back({dest_out, data_out});
        if (dest_out) m_cnt1++; else m_cnt0++;
      end
      if (pop_D0 || pop_D1) begin
        side = pop_D1;
        checks++;
        if (pop_D0 && pop_D1) begin
          errors++;
          $display("FAIL pop_both: got both pops want one");
        end else if (!(side ? pc1 : pc0)) begin
          errors++;
          $display("FAIL pop_empty: got pop on side %0d want no pop (can_pop=0)", side);
        end else if (pc0 && pc1 && side == last_gnt) begin
          errors++;
          $display("FAIL round_robin: got side %0d want side %0d", side, !last_gnt);
        end
        last_gnt = side;
        pops_q.push_back(side);
        if (side && n1 > 0) exp_q.push_back({1'b1, q1[0]});
        if (!side && n0 > 0) exp_q.push_back({1'b0, q0[0]});
        checks++;
        if (exp_q.size() > 2) begin
          errors++;
          $display("FAIL held: got %0d words outstanding want <= 2", exp_q.size());
        end
      end
      pc0 = D0_can_pop;
      pc1 = D1_can_pop;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    ready_in = 1'b0;
    q0.delete(); q1.delete(); n0 = 0; n1 = 0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bit ok = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(BW'(i)); q1.push_back(BW'(i + 8)); n0++; n1++;
    end
    enable = 1'b1;
    ready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_out) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_traffic: got no valid_out want valid_out"); end
    reset = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || pop_D0 !== 1'b0 || pop_D1 !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b pops=%b%b data=%h want 0", valid_out, pop_D0,
               pop_D1, data_out);
    end
    tick(); tick(); tick();
    checks++;
    if (pop_D0 !== 1'b0 || pop_D1 !== 1'b0 || valid_out !== 1'b0 || drain_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: got pops=%b%b valid=%b idle=%b want 00 0 1", pop_D0, pop_D1,
               valid_out, drain_idle);
    end
    checks++;
    if (cnt_D0 !== '0 || cnt_D1 !== '0 || dest_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d dest=%b want 0/0 0", cnt_D0, cnt_D1, dest_out);
    end
  endtask

  task automatic test_single_stream();
    logic [BW-1:0] vals [3] = '{6'h05, 6'h0A, 6'h0F};
    int  t0 = 0, t1 = 0;
    bit  ok = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin q0.push_back(vals[i]); n0++; end
    ready_in = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pop_D0) begin ok = 1'b1; break; end
    end
    t0 = cyc;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_pop: got no pop_D0 want pop_D0"); end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid_out) begin ok = 1'b1; break; end
      tick();
    end
    t1 = cyc;
    checks++;
    if (!ok || t1 - t0 != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles want 2", t1 - t0);
    end
    for (int i = 0; i < 20 && got_q.size() < 3; i++) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== {1'b0, vals[i]}) begin
        errors++;
        $display("FAIL single_word%0d: got %h want %h", i,
                 (got_q.size() > i) ? got_q[i] : {(BW+1){1'bx}}, {1'b0, vals[i]});
      end
    end
  endtask

  task automatic test_round_robin();
    logic [BW:0] exp_w [4] = '{7'h11, 7'h61, 7'h12, 7'h62};
    bit          exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit          ok = 1'b0;
    do_reset();
    q0.push_back(6'h11); q0.push_back(6'h12); n0 = 2;
    q1.push_back(6'h21); q1.push_back(6'h22); n1 = 2;
    ready_in = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pops_q.size() >= 4 && got_q.size() >= 4) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d words want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pops_q.size() <= i || got_q.size() <= i || pops_q[i] !== exp_s[i] ||
          got_q[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL rr_order%0d: got side %0d word %h want side %0d word %h", i,
                 (pops_q.size() > i) ? pops_q[i] : 1'b0,
                 (got_q.size() > i) ? got_q[i] : {(BW+1){1'bx}}, exp_s[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] vals [8];
    logic [BW-1:0] held_val = '0;
    bit            ok = 1'b0, seen = 1'b0, stable = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      vals[i] = BW'($urandom);
      q0.push_back(vals[i]); n0++;
    end
    ready_in = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_out && !seen) begin seen = 1'b1; held_val = data_out; end
      else if (seen && (!valid_out || data_out !== held_val)) stable = 1'b0;
    end
    checks++;
    if (pops_q.size() != 2) begin
      errors++;
      $display("FAIL bp_pops: got %0d pops want 2", pops_q.size());
    end
    checks++;
    if (!seen || !stable || data_out !== vals[0]) begin
      errors++;
      $display("FAIL bp_stable: got %h (stable=%b) want %h held", data_out, stable, vals[0]);
    end
    ready_in = 1'b1;
    for (int i = 0; i < 10 && got_q.size() < 2; i++) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== {1'b0, vals[i]}) begin
        errors++;
        $display("FAIL bp_release%0d: got %h want %h", i,
                 (got_q.size() > i) ? got_q[i] : {(BW+1){1'bx}}, {1'b0, vals[i]});
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (pops_q.size() > 2) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_resume: got %0d pops want > 2", pops_q.size()); end
    for (int i = 0; i < 40 && got_q.size() < 8; i++) tick();
    checks++;
    if (got_q.size() != 8 || got_q[7] !== {1'b0, vals[7]}) begin
      errors++;
      $display("FAIL bp_drain: got %0d words want 8", got_q.size());
    end
  endtask

  task automatic test_flush();
    logic [BW-1:0] vals [6];
    int            np = 0;
    bit            ok = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vals[i] = BW'($urandom);
      q1.push_back(vals[i]); n1++;
    end
    ready_in = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pop_D1) begin ok = 1'b1; break; end
    end
    tick();
    enable = 1'b0;
    np = pops_q.size() + (pop_D1 ? 1 : 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (drain_idle) break;
    end
    tick();
    checks++;
    if (!ok || drain_idle !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: got drain_idle=%b want 1", drain_idle);
    end
    checks++;
    if (pops_q.size() != np || got_q.size() != np || n1 != 6 - np) begin
      errors++;
      $display("FAIL flush_count: got pops=%0d delivered=%0d want %0d", pops_q.size(),
               got_q.size(), np);
    end
    checks++;
    if (np < 1 || got_q.size() < 1 || got_q[got_q.size()-1] !== {1'b1, vals[np-1]}) begin
      errors++;
      $display("FAIL flush_last: got %0d words want last word %h", got_q.size(),
               {1'b1, vals[(np > 0) ? np - 1 : 0]});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (n0 < 6 && $urandom_range(0, 2) != 0) begin q0.push_back(BW'($urandom)); n0++; end
      if (n1 < 6 && $urandom_range(0, 2) != 0) begin q1.push_back(BW'($urandom)); n1++; end
      ready_in = ($urandom_range(0, 9) < 7);
      enable = ($urandom_range(0, 19) != 0);
      tick();
    end
    enable = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n0 == 0 && n1 == 0 && exp_q.size() == 0 && !valid_out) break;
    end
    checks++;
    if (n0 != 0 || n1 != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got left %0d/%0d/%0d want 0/0/0", n0, n1, exp_q.size());
    end
    enable = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (drain_idle !== 1'b1) begin
      errors++;
      $display("FAIL random_idle: got drain_idle=%b want 1", drain_idle);
    end
  endtask

  task automatic test_counters();
    logic [CW-1:0] want0;
    do_reset();
    for (int i = 0; i < 257; i++) begin q0.push_back(BW'(i)); n0++; end
    ready_in = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2000 && got_q.size() < 257; i++) tick();
    tick();
`ifdef PCIE_DRAIN_CNT_EN
    want0 = CW'(1);
`else
    want0 = '0;
`endif
    checks++;
    if (got_q.size() != 257 || cnt_D0 !== want0 || cnt_D1 !== '0) begin
      errors++;
      $display("FAIL cnt_wrap: got words=%0d cnt=%0d/%0d want 257 %0d/0", got_q.size(), cnt_D0,
               cnt_D1, want0);
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_random();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
